// File: rtl/csh_pkg.sv
// Shared types, constants and the parity helper for the cache fill sequencer.
package csh_pkg;

  localparam int unsigned CSH_WORDS = 4;
  localparam int unsigned WIDX_W    = 2;
  localparam int unsigned WAY_N     = 4;
  localparam int unsigned DATA_W    = 36;
  localparam int unsigned TMO_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LAST = 2'd2
  } fill_state_t;

  // One cache-slice write: data in PDP-10 bit order, its parity and word index.
  typedef struct packed {
    logic [0:DATA_W-1] data;
    logic              par;
    logic [WIDX_W-1:0] adr;
  } csh_wr_t;

  // Odd parity bit: makes the total number of ones over data+bit odd.
  function automatic logic odd_par36(input logic [0:DATA_W-1] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/csh_fill_tmo.sv
// Idle-cycle counter between memory words; flags when the next idle cycle hits the limit.
module csh_fill_tmo
  import csh_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An idle cycle seen at this count is the one that reaches the limit.
  assign expired_c = (cnt_q == TMO_W'(TMO_CYCLES - 1));

endmodule

// File: rtl/csh_fill_seq.sv
// Cache fill sequencer: writes a returned quadword into one cache way in wrap-around order.
module csh_fill_seq
  import csh_pkg::*;
#(
  parameter int unsigned WORDS      = CSH_WORDS,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req_h,
  input  logic [1:0]        fill_way_h,
  input  logic [1:0]        fill_wd_h,
  input  logic              mem_valid_h,
  input  logic [0:35]       mem_data_h,
  input  logic              mem_par_h,
  output logic [0:35]       mem_to_cache_h,
  output logic              csh_par_bit_in_h,
  output logic [1:0]        cache_adr_34_35_h,
  output logic [3:0]        cache_wr_l,
  output logic              fill_busy_h,
  output logic              fill_done_h,
  output logic              fill_abort_h,
  output logic              par_err_h
);

  localparam csh_wr_t WR_RST = '{data: '0, par: 1'b1, adr: '0};

  fill_state_t       state_q, state_d;
  logic [1:0]        way_q, way_d;
  logic [WIDX_W-1:0] start_q, start_d;
  logic [WIDX_W-1:0] cnt_q, cnt_d;
  csh_wr_t           wr_q, wr_d;
  logic [WAY_N-1:0]  wr_l_q, wr_l_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              perr_q, perr_d;
  logic              tmo_clr_c, tmo_en_c, tmo_expired_c;

  csh_fill_tmo #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmo_clr_c),
    .en_i     (tmo_en_c),
    .expired_c(tmo_expired_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    wr_l_d    = '1;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    perr_d    = perr_q;
    tmo_clr_c = 1'b0;
    tmo_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        // A request landing on the done cycle belongs to the old fill and is dropped.
        if (fill_req_h && !done_q) begin
          state_d   = WAIT;
          way_d     = fill_way_h;
          start_d   = fill_wd_h;
          cnt_d     = '0;
          perr_d    = 1'b0;
          busy_d    = 1'b1;
          tmo_clr_c = 1'b1;
        end
      end
      WAIT: begin
        if (mem_valid_h) begin
          wr_d.data = mem_data_h;
          wr_d.par  = odd_par36(mem_data_h);
          wr_d.adr  = start_q + cnt_q;
          wr_l_d    = ~(WAY_N'(1) << way_q);
          cnt_d     = cnt_q + WIDX_W'(1);
          tmo_clr_c = 1'b1;
          // Memory word is stored with regenerated parity; the error is only reported.
          if (!(^{mem_data_h, mem_par_h})) begin
            perr_d = 1'b1;
          end
          if (cnt_q == WIDX_W'(WORDS - 1)) begin
            state_d = LAST;
          end
        end else begin
          tmo_en_c = 1'b1;
          if (tmo_expired_c) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b1;
          end
        end
      end
      LAST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      way_q   <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      wr_q    <= WR_RST;
      wr_l_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wr_l_q  <= wr_l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      perr_q  <= perr_d;
    end
  end

  assign mem_to_cache_h    = wr_q.data;
  assign csh_par_bit_in_h  = wr_q.par;
  assign cache_adr_34_35_h = wr_q.adr;
  assign cache_wr_l        = wr_l_q;
  assign fill_busy_h       = busy_q;
  assign fill_done_h       = done_q;
  assign fill_abort_h      = abort_q;
  assign par_err_h         = perr_q;

endmodule

// File: tb/tb_csh_fill_seq.sv
// Self-checking bench for csh_fill_seq: vector table, directed corner sequences, random traffic.
module tb_csh_fill_seq;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset, fill_req_h, mem_valid_h, mem_par_h;
  logic [1:0]  fill_way_h, fill_wd_h;
  logic [35:0] mem_data_h;
  logic [35:0] mem_to_cache_h;
  logic        csh_par_bit_in_h;
  logic [1:0]  cache_adr_34_35_h;
  logic [3:0]  cache_wr_l;
  logic        fill_busy_h, fill_done_h, fill_abort_h, par_err_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csh_fill_seq #(.WORDS(4), .TMO_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .fill_req_h       (fill_req_h),
    .fill_way_h       (fill_way_h),
    .fill_wd_h        (fill_wd_h),
    .mem_valid_h      (mem_valid_h),
    .mem_data_h       (mem_data_h),
    .mem_par_h        (mem_par_h),
    .mem_to_cache_h   (mem_to_cache_h),
    .csh_par_bit_in_h (csh_par_bit_in_h),
    .cache_adr_34_35_h(cache_adr_34_35_h),
    .cache_wr_l       (cache_wr_l),
    .fill_busy_h      (fill_busy_h),
    .fill_done_h      (fill_done_h),
    .fill_abort_h     (fill_abort_h),
    .par_err_h        (par_err_h)
  );

  // Reference model: an open fill, its way/start, words taken and idle cycles since the last event.
  bit          m_open, m_lastpend, m_perr;
  int          m_way, m_start, m_n, m_idle;
  logic [3:0]  e_wr_l;
  logic [35:0] e_data;
  bit          e_par, e_busy, e_done, e_abort, e_dp;
  int          e_adr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit good_par(input logic [35:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic model(input bit rst, input bit req, input int way, input int wd,
                       input bit val, input logic [35:0] d, input bit p);
    bit prev_done;
    prev_done = e_done;
    if (rst) begin
      m_open = 0; m_lastpend = 0; m_perr = 0;
      e_wr_l = 4'hF; e_data = '0; e_par = 1; e_adr = 0;
      e_busy = 0; e_done = 0; e_abort = 0; e_dp = 1;
      return;
    end
    e_wr_l = 4'hF; e_done = 0; e_abort = 0; e_dp = 0;
    if (m_lastpend) begin
      m_lastpend = 0; m_open = 0; e_done = 1;
    end else if (m_open) begin
      if (val) begin
        e_data = d;
        e_par  = good_par(d);
        e_adr  = (m_start + m_n) % 4;
        e_wr_l[m_way] = 1'b0;
        e_dp   = 1;
        if ((($countones(d) + int'(p)) % 2) == 0) m_perr = 1;
        m_n++;
        m_idle = 0;
        if (m_n == 4) m_lastpend = 1;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_open = 0; e_done = 1; e_abort = 1;
        end
      end
    end else if (req && !prev_done) begin
      m_open = 1; m_way = way; m_start = wd; m_n = 0; m_idle = 0; m_perr = 0;
    end
    e_busy = m_open;
  endtask

  task automatic compare_all();
    chk("wr_l",  64'(cache_wr_l),   64'(e_wr_l));
    chk("busy",  64'(fill_busy_h),  64'(e_busy));
    chk("done",  64'(fill_done_h),  64'(e_done));
    chk("abort", 64'(fill_abort_h), 64'(e_abort));
    chk("perr",  64'(par_err_h),    64'(m_perr));
    if (e_dp) begin
      chk("data", 64'(mem_to_cache_h),    64'(e_data));
      chk("cpar", 64'(csh_par_bit_in_h),  64'(e_par));
      chk("adr",  64'(cache_adr_34_35_h), 64'(e_adr));
    end
  endtask

  task automatic step(input bit rst, input bit req, input int way, input int wd,
                      input bit val, input logic [35:0] d, input bit p);
    reset = rst; fill_req_h = req; fill_way_h = 2'(way); fill_wd_h = 2'(wd);
    mem_valid_h = val; mem_data_h = d; mem_par_h = p;
    @(posedge clk);
    model(rst, req, way, wd, val, d, p);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic word(input logic [35:0] d);
    step(0, 0, 0, 0, 1, d, good_par(d));
  endtask

  task automatic req(input int way, input int wd);
    step(0, 1, way, wd, 0, '0, 0);
  endtask

  typedef struct {
    bit          req;
    int          way;
    int          wd;
    bit          val;
    logic [35:0] d;
    bit          p;
    logic [3:0]  x_wr_l;
    int          x_adr;
    bit          x_cpar;
    bit          x_busy;
    bit          x_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int seen;
    int pv;

    tbl[0] = '{1, 1, 0, 0, 36'o0, 0, 4'b1111, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 0, 1, 36'o1, 0, 4'b1101, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 36'o2, 0, 4'b1101, 1, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 36'o3, 1, 4'b1101, 2, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 1, 36'o4, 0, 4'b1101, 3, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 36'o0, 0, 4'b1111, 0, 0, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 36'o0, 0, 4'b1111, 0, 0, 0, 0};

    step(1, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    chk("rst_wr_l", 64'(cache_wr_l), 64'hF);
    chk("rst_cpar", 64'(csh_par_bit_in_h), 64'h1);

    // Basic fill: way 1, start 0, back-to-back words.
    foreach (tbl[i]) begin
      step(0, tbl[i].req, tbl[i].way, tbl[i].wd, tbl[i].val, tbl[i].d, tbl[i].p);
      chk("tbl_wr_l", 64'(cache_wr_l), 64'(tbl[i].x_wr_l));
      chk("tbl_busy", 64'(fill_busy_h), 64'(tbl[i].x_busy));
      chk("tbl_done", 64'(fill_done_h), 64'(tbl[i].x_done));
      if (tbl[i].x_wr_l != 4'hF) begin
        chk("tbl_adr",  64'(cache_adr_34_35_h), 64'(tbl[i].x_adr));
        chk("tbl_cpar", 64'(csh_par_bit_in_h),  64'(tbl[i].x_cpar));
        chk("tbl_data", 64'(mem_to_cache_h),    64'(tbl[i].d));
      end
    end

    // Gapped words, way 3, start 3: wrap order and one-cycle strobes, no abort.
    req(3, 3);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 5; g++) idle();
      word(36'(36'o100 + k));
      chk("gap_adr",  64'(cache_adr_34_35_h), 64'((3 + k) % 4));
      chk("gap_wr_l", 64'(cache_wr_l), 64'(4'b0111));
    end
    idle();
    chk("gap_done",  64'(fill_done_h), 64'h1);
    chk("gap_abort", 64'(fill_abort_h), 64'h0);
    idle();

    // Memory parity error: all-ones word with an even total is flagged and sticky.
    req(0, 1);
    word(36'o12);
    step(0, 0, 0, 0, 1, 36'o777777777777, 0);
    chk("perr_set",  64'(par_err_h), 64'h1);
    chk("perr_cpar", 64'(csh_par_bit_in_h), 64'h1);
    word(36'o5);
    word(36'o7);
    idle();
    chk("perr_done", 64'(par_err_h), 64'h1);
    idle();
    chk("perr_hold", 64'(par_err_h), 64'h1);
    req(2, 0);
    chk("perr_clr", 64'(par_err_h), 64'h0);
    for (int k = 0; k < 4; k++) word(36'($urandom));
    idle();
    idle();

    // Timeout after two words.
    req(2, 1);
    word(36'o21);
    word(36'o22);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      idle();
      if (fill_done_h) begin
        seen = c;
        break;
      end
    end
    chk("tmo_lat",   64'(seen), 64'(TMO));
    chk("tmo_abort", 64'(fill_abort_h), 64'h1);
    idle();

    // Stray valid in idle, a second request mid-fill, and a request on the done cycle.
    step(0, 0, 0, 0, 1, 36'o55, 0);
    chk("idle_valid", 64'(cache_wr_l), 64'hF);
    req(1, 2);
    word(36'o31);
    step(0, 1, 3, 0, 0, '0, 0);
    word(36'o32);
    chk("req2_adr",  64'(cache_adr_34_35_h), 64'h3);
    chk("req2_wr_l", 64'(cache_wr_l), 64'(4'b1101));
    step(0, 1, 0, 0, 1, 36'o33, good_par(36'o33));
    word(36'o34);
    idle();
    chk("req_done_pre", 64'(fill_done_h), 64'h1);
    req(0, 0);
    chk("req_on_done", 64'(fill_busy_h), 64'h0);

    // Reset after the second strobe, then a clean fill.
    req(0, 0);
    word(36'o41);
    word(36'o42);
    step(1, 0, 0, 0, 0, '0, 0);
    chk("mid_rst_wr_l", 64'(cache_wr_l), 64'hF);
    chk("mid_rst_busy", 64'(fill_busy_h), 64'h0);
    idle();
    req(2, 2);
    for (int k = 0; k < 4; k++) begin
      word(36'(36'o60 + k));
      chk("post_rst_adr", 64'(cache_adr_34_35_h), 64'((2 + k) % 4));
    end
    idle();
    chk("post_rst_done", 64'(fill_done_h), 64'h1);

    // Random traffic against the model.
    pv = 50;
    for (int c = 0; c < 600; c++) begin
      logic [35:0] d;
      bit v, p, r, rq;
      if (c % 40 == 0) pv = int'($urandom_range(5, 95));
      d  = {4'($urandom), $urandom};
      v  = ($urandom_range(0, 99) < pv);
      p  = good_par(d) ^ ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 199) == 0);
      rq = ($urandom_range(0, 5) == 0);
      step(r, rq, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), v, d, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
